// File: rtl/divisor_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/restador_nbit.sv
// Ripple-borrow subtractor: N chained 1-bit restador cells, a - b - bin.
module restador (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module restador_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_bin,
    output logic [N-1:0] o_d,
    output logic         o_bout
);
    logic [N:0] w_b;

    assign w_b[0] = i_bin;

    for (genvar g = 0; g < N; g++) begin : g_cell
        restador u_cell (
            .i_a    (i_a[g]),
            .i_b    (i_b[g]),
            .i_bin  (w_b[g]),
            .o_d    (o_d[g]),
            .o_bout (w_b[g+1])
        );
    end

    assign o_bout = w_b[N];
endmodule

// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up around the unsigned core).
module divisor_secuencial
    import divisor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] residuo,
    output logic             div_cero
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_q, r_div, r_coc, r_res;
    logic             r_dz;
    logic [WIDTH:0]   w_rsh, w_diff;
    logic             w_bout, w_accept, w_last, w_zero;
    logic [WIDTH-1:0] w_rem_nx, w_q_nx, w_a_mag, w_b_mag;
    logic [WIDTH-1:0] w_coc_fin, w_res_fin, w_res_dz;

    assign w_accept = start && (r_state != CALC);
    assign w_last   = (r_cnt == LAST);
    assign w_zero   = (r_div == '0);

    // After a restore step R < divisor, so only WIDTH bits of R need storing;
    // the shifted R' is WIDTH+1 bits wide and cannot overflow.
    assign w_rsh = {r_rem, r_q[WIDTH-1]};

    restador_nbit #(.N(WIDTH + 1)) u_sub (
        .i_a    (w_rsh),
        .i_b    ({1'b0, r_div}),
        .i_bin  (1'b0),
        .o_d    (w_diff),
        .o_bout (w_bout)
    );

    assign w_rem_nx = w_bout ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_q_nx   = {r_q[WIDTH-2:0], ~w_bout};

`ifdef DIV_SIGNED_EN
    logic r_sign_q, r_sign_r;

    assign w_a_mag   = dividendo[WIDTH-1] ? -dividendo : dividendo;
    assign w_b_mag   = divisor[WIDTH-1]   ? -divisor   : divisor;
    assign w_coc_fin = r_sign_q ? -w_q_nx   : w_q_nx;
    assign w_res_fin = r_sign_r ? -w_rem_nx : w_rem_nx;
    // r_q still holds |dividendo| when the divisor is zero; restore its sign.
    assign w_res_dz  = r_sign_r ? -r_q : r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else if (w_accept) begin
            r_sign_q <= dividendo[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividendo[WIDTH-1];
        end
    end
`else
    assign w_a_mag   = dividendo;
    assign w_b_mag   = divisor;
    assign w_coc_fin = w_q_nx;
    assign w_res_fin = w_rem_nx;
    assign w_res_dz  = r_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) w_next = CALC;
            end
            CALC: begin
                if (w_zero || w_last) w_next = DONE;
            end
            DONE: begin
                ready  = 1'b1;
                done   = 1'b1;
                w_next = start ? CALC : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_div <= '0;
            r_coc <= '0;
            r_res <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_q   <= w_a_mag;
            r_div <= w_b_mag;
            r_dz  <= (divisor == '0);
        end else if (r_state == CALC) begin
            if (w_zero) begin
                r_coc <= '1;
                r_res <= w_res_dz;
                r_dz  <= 1'b1;
            end else begin
                assert (w_bout || !w_diff[WIDTH]);
                r_rem <= w_rem_nx;
                r_q   <= w_q_nx;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_coc <= w_coc_fin;
                    r_res <= w_res_fin;
                end
            end
        end
    end

    assign cociente = r_coc;
    assign residuo  = r_res;
    assign div_cero = r_dz;

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Multi-cycle unsigned restoring divider. Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Built from the same trial-subtract and borrow logic as the ripple subtractor. It performs the inverse of the multiplication datapath.
- Serves the arithmetic unit wherever a divide result can wait WIDTH+1 cycles.
- Uses a start/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder (minimum 2).

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- dividendo  input  WIDTH  dividend, captured on the accepting edge
- divisor  input  WIDTH  divisor, captured on the accepting edge
- ready  output  1  block can accept start (state IDLE or DONE)
- done  output  1  one-cycle pulse; cociente/residuo/div_cero valid
- cociente  output  WIDTH  quotient, held until the next accepted start
- residuo  output  WIDTH  remainder, held until the next accepted start
- div_cero  output  1  divisor was zero, held with the results

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ready=1, done=0, cociente=0, residuo=0, div_cero=0; iteration counter=0.
- States:
  - IDLE: ready=1.
  - CALC: ready=0, runs WIDTH iterations.
  - DONE: done=1, ready=1, lasts exactly one cycle.
- Acceptance:
  - At edge k with start=1 in IDLE or DONE, operands are latched. State goes to CALC with counter=0, partial remainder R (WIDTH+1 bits)=0 and Q=dividendo. div_cero clears unless divisor=0.
  - If state was DONE, this start is taken instead of returning to IDLE (back-to-back allowed).
- Iteration, at each edge in CALC:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - D = R' − {0,divisor} through the (WIDTH+1)-bit subtractor.
  - If borrow=0: R=D and the new Q LSB is 1. Else R=R' and the new Q LSB is 0. Q shifts left.
  - Counter increments; after iteration WIDTH−1 the state goes to DONE.
- Latency: DONE and done=1 appear in the cycle after edge k+WIDTH. For WIDTH=4, done is high 5 cycles after the start edge. cociente=Q and residuo=R[WIDTH-1:0] update on that same edge.
- Divide by zero: at edge k+1 the state goes straight to DONE with cociente=all ones, residuo=dividendo, div_cero=1. No iterations run.
- start while in CALC: ignored, with no effect on the running operation.
- DONE with start=0: returns to IDLE next edge. done falls; outputs hold.
- Reset mid-CALC: operation abandoned, all outputs return to reset values immediately; no done pulse.
- Arithmetic: unsigned. Invariant dividendo = cociente·divisor + residuo with residuo < divisor whenever div_cero=0. Intermediate width is WIDTH+1 so R' never overflows.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - On accept, magnitudes are latched along with sign_q = sign(dividendo) XOR sign(divisor) and sign_r = sign(dividendo).
  - The unsigned core runs unchanged. On the edge into DONE, cociente is negated if sign_q and residuo is negated if sign_r.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ −1 wraps, e.g. −8/−1 → cociente=1000, residuo=0.
  - Divide by zero: cociente=all ones (−1), residuo=dividendo, div_cero=1.
  - Latency is unchanged.
- Undefined: purely unsigned behaviour as above; no sign registers are synthesized.

Decomposition:
- Package divisor_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - default WIDTH constant;
  - counter width constant $clog2(WIDTH).
- One natural sub-module, restador_nbit: parameterized ripple subtractor with borrow-in and borrow-out, built from the 1-bit restador cell. It is instantiated once at WIDTH+1 bits for the trial subtract.

Test Plan:
- Reset, then start with dividendo=13, divisor=3 → done pulse 5 cycles after the start edge, cociente=4, residuo=1, div_cero=0, ready=1 throughout DONE.
- Start with dividendo=7, divisor=0 → done at the 2nd cycle after the start edge, cociente=1111, residuo=0111, div_cero=1. Then 15/1 back-to-back from DONE → cociente=15, residuo=0, div_cero cleared.
- Start with 2/9 → cociente=0, residuo=2. Pulse start=1 again with 5/5 during CALC → ignored; results remain 0/2, and a single done pulse is seen.
- Start 14/4, deassert rst_n at the 3rd CALC cycle → outputs go to 0 asynchronously with no done pulse. After release, start 14/4 → cociente=3, residuo=2.
- Exhaustive sweep of all 256 unsigned operand pairs (WIDTH=4) → every result satisfies the invariant, or the div_cero rule when the divisor is 0.
- With DIV_SIGNED_EN: −7/2 → cociente=1101 (−3), residuo=1111 (−1); 7/−2 → cociente=1101, residuo=0001; −8/−1 → cociente=1000, residuo=0000.
